// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported, variable-latency memory between instruction fetch and
// data access. The MEM-stage access wins unless a fetch has waited through MAX_D_RUN grants.
//
// state  | meaning
// IDLE   | no access outstanding; arbitrate pending requests
// D_WAIT | data access issued, waiting for mem_ack
// I_WAIT | fetch issued, waiting for mem_ack
// DONE   | ready pulse cycle; requesters update their requests
module mem_port_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_D_RUN = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          d_read,
  input  logic          d_write,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          stall
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    D_WAIT = 2'd1,
    I_WAIT = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0]    RUN_MAX   = 4'(MAX_D_RUN);
  localparam logic [AW-1:0] WORD_MASK = ~AW'(3);

  state_t     state;
  logic [3:0] run_cnt;
  logic       d_any;
  logic       run_full;
  logic       d_grant;

  assign d_any    = d_read | d_write;
  assign run_full = (run_cnt == RUN_MAX);
  // A waiting fetch only overrides data once the data run has hit its limit.
  assign d_grant  = d_any && !(if_req && run_full);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      run_cnt   <= 4'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (d_grant) begin
            state     <= D_WAIT;
            mem_req   <= 1'b1;
            mem_we    <= d_write;
            mem_addr  <= d_addr & WORD_MASK;
            mem_wdata <= d_wdata;
            // run_cnt < RUN_MAX whenever if_req is high here, so no overflow check needed
            run_cnt   <= if_req ? run_cnt + 4'd1 : 4'd0;
          end else if (if_req) begin
            state    <= I_WAIT;
            mem_req  <= 1'b1;
            mem_we   <= 1'b0;
            mem_addr <= if_addr & WORD_MASK;
            run_cnt  <= 4'd0;
          end
        end
        D_WAIT: begin
          if (mem_ack) begin
            state   <= DONE;
            mem_req <= 1'b0;
            d_ready <= 1'b1;
            if (!mem_we) d_rdata <= mem_rdata;
          end
        end
        I_WAIT: begin
          if (mem_ack) begin
            state    <= DONE;
            mem_req  <= 1'b0;
            if_ready <= 1'b1;
            if_rdata <= mem_rdata;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign stall = reset & ((if_req & ~if_ready) | (d_any & ~d_ready));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed reset/priority/run-limit cases, then random
// requesters against a behavioural memory with a queue-based scoreboard.
module tb_mem_port_arbiter;
  localparam int MAXR = 4;

  logic        clk = 0, reset = 0;
  logic        if_req = 0, d_read = 0, d_write = 0, mem_ack = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ready, d_ready, mem_req, mem_we, stall;

  mem_port_arbiter #(.AW(32), .DW(32), .MAX_D_RUN(MAXR)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
  } acc_t;

  int n_tests = 0, n_fail = 0;
  bit mon_en = 0, mm_en = 0;
  acc_t        i_acc_q[$], d_acc_q[$];
  logic [31:0] i_exp_q[$], d_exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, want, $time);
    end
  endtask

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] f(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  // Behavioural memory: random 0..3 wait states, plus stray acks while idle.
  int lat = -1;
  always @(negedge clk) begin
    if (mm_en) begin
      if (mem_ack) mem_ack = 0;
      else if (mem_req) begin
        if (lat < 0) lat = $urandom_range(0, 3);
        if (lat == 0) begin
          mem_ack = 1; mem_rdata = f(mem_addr); lat = -1;
        end else lat--;
      end else if ($urandom_range(0, 7) == 0) begin
        mem_ack = 1; mem_rdata = $urandom;
      end
    end
  end

  // Monitor / scoreboard.
  logic prev_req = 0;
  int   low_cnt = 2, k = 0;
  bit   cur_d = 0, dp, ip, exp_d, fell;
  acc_t cur;
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      dp = d_read | d_write;
      ip = if_req;
      fell = prev_req && !mem_req;
      check("if_ready_pulse", if_ready, fell && !cur_d);
      check("d_ready_pulse", d_ready, fell && cur_d);
      if (if_ready) begin
        check("if_q_nonempty", i_exp_q.size() > 0, 1);
        if (i_exp_q.size() > 0) check("if_rdata", if_rdata, i_exp_q.pop_front());
      end
      if (d_ready) begin
        check("d_q_nonempty", d_exp_q.size() > 0, 1);
        if (d_exp_q.size() > 0) check("d_rdata", d_rdata, d_exp_q.pop_front());
      end
      check("stall", stall, (ip & ~if_ready) | (dp & ~d_ready));
      if (mem_req && !prev_req) begin
        check("req_gap", low_cnt >= 2, 1);
        check("grant_has_req", dp | ip, 1);
        exp_d = dp && !(ip && k == MAXR);
        cur_d = exp_d;
        if (exp_d) begin
          check("d_acc_q_nonempty", d_acc_q.size() > 0, 1);
          if (d_acc_q.size() > 0) cur = d_acc_q.pop_front();
          k = ip ? ((k < MAXR) ? k + 1 : MAXR) : 0;
        end else begin
          check("i_acc_q_nonempty", i_acc_q.size() > 0, 1);
          if (i_acc_q.size() > 0) cur = i_acc_q.pop_front();
          k = 0;
        end
        check("grant_addr", mem_addr, cur.addr);
        check("grant_we", mem_we, cur.we);
        if (cur.we) check("grant_wdata", mem_wdata, cur.wdata);
      end else if (mem_req) begin
        check("hold_addr", mem_addr, cur.addr);
        check("hold_we", mem_we, cur.we);
        if (cur.we) check("hold_wdata", mem_wdata, cur.wdata);
      end
    end
    low_cnt  = mem_req ? 0 : ((low_cnt < 10) ? low_cnt + 1 : 10);
    prev_req = mem_req;
  end

  task automatic do_ack(input logic [31:0] rd);
    mem_ack = 1; mem_rdata = rd;
    @(negedge clk);
    mem_ack = 0;
  endtask

  task automatic wait_req();
    int c = 0;
    while (!mem_req && c < 10) begin @(negedge clk); c++; end
    check("req_timeout", mem_req, 1);
  endtask

  task automatic run_if(input int n);
    for (int i = 0; i < n; i++) begin
      int c;
      acc_t x;
      if_addr = $urandom;
      x.addr = if_addr & ~32'h3; x.we = 0; x.wdata = 0;
      i_acc_q.push_back(x);
      i_exp_q.push_back(f(x.addr));
      if_req = 1;
      c = 0;
      do begin @(negedge clk); c++; end while (!if_ready && c < 300);
      check("if_timeout", if_ready, 1);
      if_req = 0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic run_d(input int n);
    logic [31:0] d_last = 0;
    for (int i = 0; i < n; i++) begin
      int c, op;
      acc_t x;
      op = $urandom_range(0, 2);
      d_read = (op != 1); d_write = (op != 0);
      d_addr = $urandom; d_wdata = $urandom;
      x.addr = d_addr & ~32'h3; x.we = d_write; x.wdata = d_wdata;
      d_acc_q.push_back(x);
      if (!d_write) d_last = f(x.addr);
      d_exp_q.push_back(d_last);
      c = 0;
      do begin @(negedge clk); c++; end while (!d_ready && c < 300);
      check("d_timeout", d_ready, 1);
      d_read = 0; d_write = 0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    int is_d;
    int order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

    // Reset held with a fetch pending and ack high.
    if_req = 1; mem_ack = 1; if_addr = 32'h0000_0013;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mem_req", mem_req, 0);
      check("rst_if_ready", if_ready, 0);
      check("rst_d_ready", d_ready, 0);
      check("rst_stall", stall, 0);
    end
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_d_rdata", d_rdata, 0);
    reset = 1; mem_ack = 0;

    // Lone fetch, ack two cycles into the request.
    @(negedge clk);
    check("fetch_req", mem_req, 1);
    check("fetch_addr", mem_addr, 32'h10);
    check("fetch_we", mem_we, 0);
    check("fetch_stall0", stall, 1);
    @(negedge clk);
    check("fetch_stall1", stall, 1);
    check("fetch_ready_early", if_ready, 0);
    do_ack(32'h8C22_0004);
    check("fetch_ready", if_ready, 1);
    check("fetch_rdata", if_rdata, 32'h8C22_0004);
    check("fetch_stall_done", stall, 0);
    check("fetch_req_drop", mem_req, 0);
    if_req = 0;
    @(negedge clk);
    check("fetch_ready_once", if_ready, 0);

    // Simultaneous fetch and data write: data first.
    if_req = 1; d_write = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
    wait_req();
    check("prio_we", mem_we, 1);
    check("prio_addr", mem_addr, 32'h40);
    check("prio_wdata", mem_wdata, 32'hDEAD_BEEF);
    do_ack(32'h1234_5678);
    check("prio_d_ready", d_ready, 1);
    check("prio_no_if_ready", if_ready, 0);
    check("prio_d_rdata", d_rdata, 0);
    d_write = 0;
    wait_req();
    check("prio_then_fetch_we", mem_we, 0);
    check("prio_then_fetch_addr", mem_addr, 32'h10);
    do_ack(32'h0BAD_F00D);
    check("prio_if_ready", if_ready, 1);
    check("prio_if_rdata", if_rdata, 32'h0BAD_F00D);
    if_req = 0;

    // Reset during D_WAIT; the late ack must be ignored.
    d_read = 1; d_addr = 32'h80;
    wait_req();
    reset = 0;
    @(negedge clk);
    check("abort_req", mem_req, 0);
    check("abort_stall", stall, 0);
    reset = 1; d_read = 0; mem_ack = 1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    mem_ack = 0;
    check("abort_no_ready", d_ready, 0);
    check("abort_req_low", mem_req, 0);
    @(negedge clk);
    check("abort_no_ready2", d_ready, 0);
    check("abort_rdata", d_rdata, 0);
    if_req = 1; if_addr = 32'h44;
    @(negedge clk);
    check("abort_idle_grant", mem_req, 1);
    check("abort_idle_addr", mem_addr, 32'h44);
    do_ack(32'h77);
    check("abort_if_rdata", if_rdata, 32'h77);
    if_req = 0;

    // Stray ack in IDLE, then an address change during D_WAIT.
    mem_ack = 1;
    @(negedge clk);
    mem_ack = 0;
    check("stray_if_ready", if_ready, 0);
    check("stray_d_ready", d_ready, 0);
    @(negedge clk);
    check("stray_d_ready2", d_ready, 0);
    check("stray_req", mem_req, 0);
    d_read = 1; d_addr = 32'h100;
    wait_req();
    d_addr = 32'h204;
    @(negedge clk);
    check("hold_mem_addr", mem_addr, 32'h100);
    check("hold_no_ready", d_ready, 0);
    do_ack(32'hCAFE_0001);
    check("hold_d_ready", d_ready, 1);
    check("hold_d_rdata", d_rdata, 32'hCAFE_0001);
    d_read = 0;

    // Fetch held against a continuous data stream.
    @(negedge clk);
    if_req = 1; if_addr = 32'h1000; d_read = 1; d_addr = 32'h2000;
    for (int i = 0; i < 10; i++) begin
      wait_req();
      is_d = (mem_addr == 32'h2000);
      check("grant_order", is_d, order[i]);
      do_ack(32'h0);
    end
    if_req = 0; d_read = 0;

    // Random traffic against the scoreboard.
    reset = 0;
    @(negedge clk);
    reset = 1;
    k = 0;
    mon_en = 1; mm_en = 1;
    fork
      run_if(60);
      run_d(60);
    join
    repeat (6) @(negedge clk);
    check("leftover_if", i_exp_q.size() + i_acc_q.size(), 0);
    check("leftover_d", d_exp_q.size() + d_acc_q.size(), 0);
    mon_en = 0; mm_en = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, t=%0t", $time);
    $fatal(1);
  end
endmodule
